// File: rtl/ps2_pkg.sv
// Shared PS/2 constants, FSM state type and frame packing for the device transmitter and host receiver.
package ps2_pkg;

    localparam int unsigned PS2_FRAME_BITS = 11;
    localparam int unsigned FIFO_DEPTH     = 8;
    localparam int unsigned FIFO_AW        = 3;
    localparam int unsigned FIFO_CW        = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        GAP  = 2'd3
    } ps2_state_e;

    // Field order matches the wire: start bit is bit 0 and leaves first.
    typedef struct packed {
        logic       stop;
        logic       parity;
        logic [7:0] data;
        logic       start;
    } ps2_frame_t;

    function automatic ps2_frame_t ps2_pack_frame(input logic [7:0] d);
        ps2_frame_t f;
        f.stop   = 1'b1;
        f.parity = ~^d;
        f.data   = d;
        f.start  = 1'b0;
        return f;
    endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// 8x8 synchronous FIFO feeding the PS/2 transmitter; a push while full is dropped and flagged.
module ps2_tx_fifo
    import ps2_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         i_wdata,
    input  logic               i_push,
    input  logic               i_pop,
    output logic [7:0]         o_rdata_c,
    output logic [FIFO_CW-1:0] o_count,
    output logic               o_full,
    output logic               o_dropped_c
);

    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_CW-1:0] r_count;
    logic               r_full;

    logic               w_wr_ok;
    logic               w_rd_ok;
    logic [FIFO_CW-1:0] w_count_nxt;

    // Full is judged on the pre-pop count, so a write while full drops even alongside a pop.
    assign w_wr_ok     = i_push & ~r_full;
    assign w_rd_ok     = i_pop & (r_count != '0);
    assign w_count_nxt = r_count + FIFO_CW'(w_wr_ok) - FIFO_CW'(w_rd_ok);

    assign o_rdata_c   = r_mem[r_rptr];
    assign o_dropped_c = i_push & r_full;
    assign o_count     = r_count;
    assign o_full      = r_full;

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= r_wptr + FIFO_AW'(1);
            end
            if (w_rd_ok) begin
                r_rptr <= r_rptr + FIFO_AW'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == FIFO_CW'(FIFO_DEPTH));
        end
    end

endmodule

// File: rtl/ps2_device_tx.sv
// PS/2 keyboard-side transmitter: buffers scan codes and serialises them as 11-bit frames on ps2_clk/ps2_data.
module ps2_device_tx
    import ps2_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 2500,
    parameter int unsigned GAP_CYCLES  = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] wdata,
    input  logic       wr,
    input  logic       inhibit,
    output logic       full,
    output logic       busy,
    output logic       overflow,
    output logic       ps2_clk,
    output logic       ps2_data
);

    localparam int unsigned TMAX = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX);
    localparam int unsigned BCW  = $clog2(PS2_FRAME_BITS);

    ps2_state_e                r_state;
    logic [PS2_FRAME_BITS-1:0] r_shift;
    logic [BCW-1:0]            r_bitcnt;
    logic [TW-1:0]             r_timer;
    logic                      r_ps2_clk;
    logic                      r_ps2_data;
    logic                      r_busy;
    logic                      r_overflow;

    ps2_state_e                w_state_nxt;
    logic [PS2_FRAME_BITS-1:0] w_shift_nxt;
    logic [BCW-1:0]            w_bitcnt_nxt;
    logic [TW-1:0]             w_timer_nxt;
    logic                      w_data_nxt;
    logic                      w_pop;
    logic [7:0]                w_rdata_c;
    logic [FIFO_CW-1:0]        w_count;
    logic                      w_dropped_c;

    ps2_tx_fifo u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_wdata     (wdata),
        .i_push      (wr),
        .i_pop       (w_pop),
        .o_rdata_c   (w_rdata_c),
        .o_count     (w_count),
        .o_full      (full),
        .o_dropped_c (w_dropped_c)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_bitcnt_nxt = r_bitcnt;
        w_timer_nxt  = r_timer + TW'(1);
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                w_timer_nxt = '0;
                if ((w_count != '0) && !inhibit) begin
                    w_pop        = 1'b1;
                    w_shift_nxt  = ps2_pack_frame(w_rdata_c);
                    w_bitcnt_nxt = '0;
                    w_state_nxt  = HIGH;
                end
            end
            HIGH: begin
                if (r_timer == TW'(HALF_PERIOD - 1)) begin
                    w_timer_nxt = '0;
                    w_state_nxt = LOW;
                end
            end
            LOW: begin
                if (r_timer == TW'(HALF_PERIOD - 1)) begin
                    w_timer_nxt = '0;
                    if (r_bitcnt == BCW'(PS2_FRAME_BITS - 1)) begin
                        w_state_nxt = GAP;
                    end else begin
                        w_shift_nxt  = {1'b1, r_shift[PS2_FRAME_BITS-1:1]};
                        w_bitcnt_nxt = r_bitcnt + BCW'(1);
                        w_state_nxt  = HIGH;
                    end
                end
            end
            GAP: begin
                if (r_timer == TW'(GAP_CYCLES - 1)) begin
                    w_timer_nxt = '0;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Data only moves on entry to HIGH, so it is held across every falling edge.
        case (w_state_nxt)
            HIGH:    w_data_nxt = w_shift_nxt[0];
            LOW:     w_data_nxt = r_ps2_data;
            default: w_data_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_shift    <= '1;
            r_bitcnt   <= '0;
            r_timer    <= '0;
            r_ps2_clk  <= 1'b1;
            r_ps2_data <= 1'b1;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_bitcnt   <= w_bitcnt_nxt;
            r_timer    <= w_timer_nxt;
            r_ps2_clk  <= (w_state_nxt != LOW);
            r_ps2_data <= w_data_nxt;
            r_busy     <= (w_state_nxt != IDLE);
            r_overflow <= r_overflow | w_dropped_c;
        end
    end

    assign ps2_clk  = r_ps2_clk;
    assign ps2_data = r_ps2_data;
    assign busy     = r_busy;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_ps2_device_tx.sv
// Scoreboard bench: directed writes queue hand-computed frames; a line monitor decodes and compares them.
module tb_ps2_device_tx;

    localparam int unsigned H = 4;
    localparam int unsigned G = 8;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic [7:0] wdata   = 8'h00;
    logic       wr      = 1'b0;
    logic       inhibit = 1'b0;
    logic       full;
    logic       busy;
    logic       overflow;
    logic       ps2_clk;
    logic       ps2_data;

    ps2_device_tx #(.HALF_PERIOD(H), .GAP_CYCLES(G)) dut (
        .clk      (clk),
        .rst      (rst),
        .wdata    (wdata),
        .wr       (wr),
        .inhibit  (inhibit),
        .full     (full),
        .busy     (busy),
        .overflow (overflow),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // Expected frames, bit 0 = start bit (first on the wire)
    logic [10:0] exp_q[$];

    // Line monitor state
    int          mon_bits       = 0;
    logic [10:0] mon_frame      = '0;
    logic        prev_clk       = 1'b1;
    logic        prev_data      = 1'b1;
    logic        fall_bit       = 1'b1;
    int          stable_cnt     = 0;
    bit          stab_err       = 1'b0;
    int          frames_done    = 0;
    int          total_falls    = 0;
    int          start_cyc      = 0;
    int          prev_start_cyc = 0;
    int          first_fall_cyc = 0;
    int          last_rise_cyc  = 0;

    always @(negedge clk) begin
        logic [10:0] e;
        if (rst) begin
            mon_bits   = 0;
            stab_err   = 1'b0;
            prev_clk   = 1'b1;
            prev_data  = 1'b1;
            stable_cnt = 0;
        end else begin
            if (ps2_data !== prev_data) stable_cnt = 0;
            else stable_cnt++;
            if (mon_bits == 0 && ps2_clk && prev_data && !ps2_data && busy) begin
                prev_start_cyc = start_cyc;
                start_cyc      = cyc;
            end
            if (!ps2_clk && prev_clk) begin
                total_falls++;
                if (mon_bits == 0) first_fall_cyc = cyc;
                if (stable_cnt < int'(H)) stab_err = 1'b1;
                fall_bit  = ps2_data;
                mon_frame = {ps2_data, mon_frame[10:1]};
                mon_bits++;
            end else if (!ps2_clk && (ps2_data !== fall_bit)) begin
                stab_err = 1'b1;
            end
            if (ps2_clk && !prev_clk) begin
                last_rise_cyc = cyc;
                if (mon_bits == 11) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL frame_unexpected: got 0x%0h expected no frame", mon_frame);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_bits", 32'(mon_frame), 32'(e));
                        check("frame_stable", 32'(stab_err), 32'd0);
                    end
                    frames_done++;
                    mon_bits = 0;
                    stab_err = 1'b0;
                end
            end
            prev_clk  = ps2_clk;
            prev_data = ps2_data;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wr_byte(input logic [7:0] b, input logic [10:0] f, input bit push);
        wr    = 1'b1;
        wdata = b;
        if (push) exp_q.push_back(f);
        step();
        wr = 1'b0;
    endtask

    task automatic wait_frames(input string name, input int n, input int budget);
        int target;
        int k;
        target = frames_done + n;
        k = 0;
        while (frames_done < target && k < budget) begin
            step();
            k++;
        end
        check(name, 32'(frames_done), 32'(target));
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            step();
            k++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    logic [7:0]  fifo_bytes  [8] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
    logic [10:0] fifo_frames [8] = '{11'h402, 11'h606, 11'h40E, 11'h61E, 11'h43E, 11'h67E, 11'h4FE, 11'h7FE};

    initial begin
        int t;
        int bc;
        int k;
        int f0;

        repeat (3) step();
        check("rst_ps2_clk", 32'(ps2_clk), 32'd1);
        check("rst_ps2_data", 32'(ps2_data), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        repeat (2) step();

        // Single byte 0x1C: latency, frame length and busy window
        wr_byte(8'h1C, 11'h438, 1'b1);
        t = cyc;
        step();
        check("lat_start_data", 32'(ps2_data), 32'd0);
        check("lat_busy", 32'(busy), 32'd1);
        check("lat_clk_high", 32'(ps2_clk), 32'd1);
        bc = 1;
        k  = 0;
        while (busy && k < 500) begin
            step();
            k++;
            if (busy) bc++;
        end
        check("busy_cycles", 32'(bc), 32'(22 * H + G));
        check("start_latency", 32'(start_cyc - t), 32'd1);
        check("first_fall", 32'(first_fall_cyc - t), 32'(1 + H));
        check("active_len", 32'(last_rise_cyc - start_cyc), 32'(22 * H));
        wait_frames("frames_1c", 0, 1);

        // Back-to-back F0, 1C
        wr_byte(8'hF0, 11'h7E0, 1'b1);
        wr_byte(8'h1C, 11'h438, 1'b1);
        wait_frames("frames_f0_1c", 2, 400);
        check("b2b_spacing", 32'(start_cyc - prev_start_cyc), 32'(22 * H + G + 1));
        wait_idle("idle_after_b2b", 50);

        // Fill under inhibit, ninth write dropped
        inhibit = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_byte(fifo_bytes[i], fifo_frames[i], 1'b1);
            if (i == 6) check("full_after_7", 32'(full), 32'd0);
            if (i == 7) check("full_after_8", 32'(full), 32'd1);
        end
        check("ovf_before_9", 32'(overflow), 32'd0);
        wr_byte(8'h55, 11'h000, 1'b0);
        check("ovf_after_9", 32'(overflow), 32'd1);
        check("full_after_9", 32'(full), 32'd1);
        check("inhibit_no_busy", 32'(busy), 32'd0);
        inhibit = 1'b0;
        wait_frames("frames_fifo8", 8, 8 * (22 * H + G + 1) + 50);
        check("full_drained", 32'(full), 32'd0);
        check("sb_after_fifo", 32'(exp_q.size()), 32'd0);
        wait_idle("idle_after_fifo", 50);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Inhibit mid-frame: current frame completes, next waits
        wr_byte(8'h12, 11'h624, 1'b1);
        wr_byte(8'h34, 11'h468, 1'b1);
        k = 0;
        while (mon_bits < 5 && k < 200) begin
            step();
            k++;
        end
        inhibit = 1'b1;
        wait_frames("frame_under_inhibit", 1, 200);
        wait_idle("idle_under_inhibit", 50);
        repeat (20) step();
        check("inh_hold_busy", 32'(busy), 32'd0);
        check("inh_hold_clk", 32'(ps2_clk), 32'd1);
        check("inh_hold_data", 32'(ps2_data), 32'd1);
        inhibit = 1'b0;
        t = cyc;
        step();
        check("inh_release_start", 32'(start_cyc - t), 32'd1);
        check("inh_release_data", 32'(ps2_data), 32'd0);
        wait_frames("frame_after_inhibit", 1, 200);
        wait_idle("idle_after_inhibit", 50);

        // Reset at falling edge 5 of 0xAA
        wr_byte(8'hAA, 11'h000, 1'b0);
        k = 0;
        while (mon_bits < 6 && k < 200) begin
            step();
            k++;
        end
        check("rst_mid_at_fall5", 32'(ps2_clk), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_clk", 32'(ps2_clk), 32'd1);
        check("rst_mid_data", 32'(ps2_data), 32'd1);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_ovf", 32'(overflow), 32'd0);
        f0 = total_falls;
        repeat (40) step();
        check("rst_mid_no_edges", 32'(total_falls - f0), 32'd0);
        check("rst_mid_fifo_empty", 32'(busy), 32'd0);

        // Parity corners 0x00 and 0xFF
        wr_byte(8'h00, 11'h600, 1'b1);
        wr_byte(8'hFF, 11'h7FE, 1'b1);
        wait_frames("frames_00_ff", 2, 400);
        wait_idle("idle_end", 50);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ps2_device_tx.md
# ps2_device_tx

PS/2 device-side transmitter. It emulates a keyboard: it takes scan-code bytes from the system, buffers them in an 8-entry FIFO, and serialises each byte onto `ps2_clk`/`ps2_data` as an 11-bit PS/2 frame. The block drives the keyboard end of the link that the host-side PS/2 receiver samples. It feeds that receiver in simulation and in on-chip loopback tests.

## Interface
- `HALF_PERIOD`, default 2500: `clk` cycles per `ps2_clk` half period (≥2). Benches use 4.
- `GAP_CYCLES`, default 5000: idle cycles between frames, with clk and data high (≥1).
- `clk` input 1: system clock. Everything is on posedge.
- `rst` input 1: synchronous, active-high reset.
- `wdata` input 8: scan code to enqueue.
- `wr` input 1: enqueue strobe. Each cycle it is high counts as one write.
- `inhibit` input 1: host inhibit. New frames do not start while it is high.
- `full` output 1: FIFO holds 8 bytes.
- `busy` output 1: a frame or its trailing gap is in progress.
- `overflow` output 1: sticky. Set when a write is dropped.
- `ps2_clk` output 1: PS/2 clock. Idles high.
- `ps2_data` output 1: PS/2 data. Idles high.

## Operation
- Reset values: `ps2_clk`=1, `ps2_data`=1, `busy`=0, `full`=0, `overflow`=0. FIFO count is 0 and both pointers are 0.
- FIFO:
  - 8×8 storage with 3-bit read/write pointers that wrap mod 8, plus a 4-bit count.
  - `full` = (count==8).
  - A write while `full` is dropped and sets `overflow`. `full` is evaluated before any same-cycle pop, so the byte is dropped even if a pop happens that cycle.
  - A write and a pop in the same cycle with 0<count<8 leave count unchanged.
- Frame format, in transmit order:
  - start bit 0;
  - `d[0]`..`d[7]`, LSB first;
  - odd parity = ~^d;
  - stop bit 1.
- The block builds an 11-bit shift register {1, ~^d, d, 0} at load time and shifts it right, one bit per `ps2_clk` period.
- FSM states: IDLE, HIGH, LOW, GAP.
  - IDLE: `ps2_clk`=1, `ps2_data`=1. If count>0 and `inhibit`=0, pop the FIFO, load the shifter, clear the bit counter and the half-period timer, then go to HIGH.
  - HIGH: `ps2_clk`=1 and `ps2_data`=shifter[0]. After `HALF_PERIOD` cycles, go to LOW.
  - LOW: `ps2_clk`=0 and `ps2_data` is unchanged. After `HALF_PERIOD` cycles:
    - if the bit counter is 10, go to GAP;
    - otherwise shift, increment the bit counter and go to HIGH.
  - GAP: `ps2_clk`=1, `ps2_data`=1. After `GAP_CYCLES` cycles, go to IDLE.
- Data changes only at the start of a HIGH phase, so it is stable across every falling edge. The host samples on the falling edge.
- `busy` = (state != IDLE).
- `inhibit` is sampled only in IDLE. It does not abort a frame already in flight.
- An empty FIFO in IDLE leaves both lines high indefinitely.
- Reset mid-frame: on the next edge both lines go high, the FIFO is emptied and the frame is abandoned. No recovery frame is sent. The host must tolerate the truncated frame.
- Outputs are registered (no combinational path from `wr` or `inhibit` to the PS/2 lines).

## Timing
- Write-to-line latency: `wr` sampled at edge T means count>0 from T. At edge T+1, IDLE pops and `ps2_data` goes 0 (start bit). The first `ps2_clk` fall is at edge T+1+H, where H=`HALF_PERIOD`.
- Frame length: 22·H cycles with `busy` high and lines active, then `GAP_CYCLES` of GAP. Next pop happens one cycle after GAP ends.
- Back-to-back bytes: start-to-start spacing = 22·H + `GAP_CYCLES` + 1.
- Falling edge k (k=0..10) occurs at T+1+(2k+1)·H. Data bit k is valid from T+1+2k·H until T+1+(2k+2)·H.

## Structure
- Package `ps2_pkg` holds:
  - `PS2_FRAME_BITS`=11;
  - the FSM state enum {IDLE, HIGH, LOW, GAP};
  - the frame-packing function (byte → 11-bit frame).
- The host receiver imports the same constants.
- One sub-module, `ps2_tx_fifo`: an 8×8 synchronous FIFO with push, pop, count, full and dropped-write strobe.
- The FSM, timers and shifter live in `ps2_device_tx`.

## Test plan
All scenarios use H=4, `GAP_CYCLES`=8.
- Single byte 0x1C: ps2_data over the 11 falling edges = 0,0,0,1,1,1,0,0,0,0,1 (parity 0). `busy` is high for 88 cycles, then 8 cycles of GAP. The loopback receiver reports 0x1C.
- Byte 0xF0 then 0x1C written on consecutive cycles: two frames spaced 97 cycles start-to-start. F0 parity bit = 1. Decoded order is F0, 1C.
- Nine writes with no pops (`inhibit`=1): `full` rises after the 8th write. The 9th byte is dropped and `overflow`=1. After `inhibit` drops, exactly 8 frames are sent, in order.
- `inhibit` asserted mid-frame: the current frame completes. The next frame waits until `inhibit`=0, then starts 1 cycle after IDLE sees it low.
- `rst` asserted at falling edge 5 of a 0xAA frame: the next cycle has clk=1, data=1, FIFO empty, `busy`=0. No further edges occur.
- Write 0x00 and 0xFF: parity bits are 1 and 1. Stop bit is 1 on both. Data is stable for H cycles on each side of every fall.
